// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state/op encodings and counter sizing for multdiv_iter
package multdiv_pkg;
   typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
   typedef enum logic {OP_MULT, OP_DIV} op_t;
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: wrapping iteration counter with sync clear and terminal-count flag
module mod_n_counter #(
   parameter int W  = 4,
   parameter int TC = 7
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tc_o = cnt_q == W'(TC);
   always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative radix-2 shift-add multiplier / restoring divider
module multdiv_iter
   import multdiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_result_hi,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   localparam int CW = cnt_w(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   state_t state_q, state_d;
   op_t op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, md_q, md_d;
   logic [WIDTH-1:0] res_q, res_d, reshi_q, reshi_d;
   logic exc_q, exc_d;
   logic start, tc, a_neg, b_neg, sgn_neg, ge;
   logic [WIDTH-1:0] a_mag, b_mag, diff, quo, rem;
   logic [WIDTH:0] sum, shl;
   logic [2*WIDTH-1:0] prod;
   assign start   = ctrl_MULT | ctrl_DIV;
   assign a_neg   = SIGNED && a_q[WIDTH-1];
   assign b_neg   = SIGNED && b_q[WIDTH-1];
   assign sgn_neg = a_neg ^ b_neg;
   assign a_mag   = a_neg ? -a_q : a_q;
   assign b_mag   = b_neg ? -b_q : b_q;
   assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
   assign shl     = {hi_q, lo_q[WIDTH-1]};
   assign ge      = shl >= {1'b0, md_q};
   // partial remainder stays below the divisor, so the subtraction fits WIDTH bits
   assign diff    = shl[WIDTH-1:0] - md_q;
   assign prod    = sgn_neg ? -{hi_q, lo_q} : {hi_q, lo_q};
   assign quo     = sgn_neg ? -lo_q : lo_q;
   assign rem     = a_neg ? -hi_q : hi_q;
   mod_n_counter #(.W(CW), .TC(WIDTH-1)) u_cnt (
      .clk_i(clock), .rst_i(reset), .clr_i(start), .en_i(state_q == RUN), .tc_o(tc)
   );
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      md_d    = md_q;
      res_d   = res_q;
      reshi_d = reshi_q;
      exc_d   = exc_q;
      case (state_q)
         PREP: begin
            hi_d    = '0;
            lo_d    = op_q == OP_MULT ? b_mag : a_mag;
            md_d    = op_q == OP_MULT ? a_mag : b_mag;
            state_d = (op_q == OP_DIV && b_q == '0) ? DONE : RUN;
            if (op_q == OP_DIV && b_q == '0) begin
               res_d   = '0;
               reshi_d = a_q;
               exc_d   = 1'b1;
            end
         end
         RUN: begin
            state_d = tc ? FIX : RUN;
            hi_d    = op_q == OP_MULT ? sum[WIDTH:1] : ge ? diff : shl[WIDTH-1:0];
            lo_d    = op_q == OP_MULT ? {sum[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], ge};
         end
         FIX: begin
            state_d = DONE;
            res_d   = op_q == OP_MULT ? prod[WIDTH-1:0] : quo;
            reshi_d = op_q == OP_MULT ? prod[2*WIDTH-1:WIDTH] : rem;
            exc_d   = op_q == OP_MULT
                    ? prod[2*WIDTH-1:WIDTH] != (SIGNED ? {WIDTH{prod[WIDTH-1]}} : '0)
                    : SIGNED && a_q == MIN && b_q == '1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // a start aborts whatever is in flight and leaves the visible outputs untouched
      if (start) begin
         state_d = PREP;
         op_d    = ctrl_MULT ? OP_MULT : OP_DIV;
         a_d     = data_operandA;
         b_d     = data_operandB;
         res_d   = res_q;
         reshi_d = reshi_q;
         exc_d   = exc_q;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_MULT;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         md_q    <= '0;
         res_q   <= '0;
         reshi_q <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         md_q    <= md_d;
         res_q   <= res_d;
         reshi_q <= reshi_d;
         exc_q   <= exc_d;
      end
   end
   assign data_result    = res_q;
   assign data_result_hi = reshi_q;
   assign data_exception = exc_q;
   assign data_resultRDY = state_q == DONE;
   assign busy           = state_q == PREP || state_q == RUN || state_q == FIX;
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: scoreboard bench for multdiv_iter with WIDTH=32, SIGNED=1
module tb_multdiv_iter;
   typedef struct {
      int          cyc;
      logic [31:0] res;
      logic [31:0] hi;
      logic        exc;
   } exp_t;
   logic clk = 0, rst = 1, cm = 0, cd = 0;
   logic [31:0] opa = '0, opb = '0, res, res_hi;
   logic exc, rdy, busy;
   int cyc = 0, checks = 0, errors = 0;
   exp_t sb[$];
   exp_t e;
   multdiv_iter #(.WIDTH(32), .SIGNED(1)) dut (
      .clock(clk), .reset(rst), .data_operandA(opa), .data_operandB(opb),
      .ctrl_MULT(cm), .ctrl_DIV(cd), .data_result(res), .data_result_hi(res_hi),
      .data_exception(exc), .data_resultRDY(rdy), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (rdy) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            chk("result", 64'(res), 64'(e.res));
            chk("result_hi", 64'(res_hi), 64'(e.hi));
            chk("exception", 64'(exc), 64'(e.exc));
         end
      end
   end
   task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] er, input logic [31:0] eh,
                        input bit ee, input int lat);
      cm  = m;
      cd  = d;
      opa = a;
      opb = b;
      if (push) sb.push_back('{cyc + lat, er, eh, ee});
      @(posedge clk);
      #1;
      cm = 0;
      cd = 0;
   endtask
   task automatic wait_until(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_drain_left"}, 64'(sb.size()), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_result", 64'(res), 64'd0);
      chk("rst_result_hi", 64'(res_hi), 64'd0);
      chk("rst_exception", 64'(exc), 64'd0);
      chk("rst_rdy", 64'(rdy), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst = 0;
      t = cyc;
      issue(1, 0, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 35);
      @(negedge clk);
      chk("busy_T+1", 64'(busy), 64'd1);
      wait_until(t + 34);
      @(negedge clk);
      chk("busy_T+34", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("busy_T+35", 64'(busy), 64'd0);
      drain("mult_7x-3");
      issue(1, 0, 32'h40000000, 32'd4, 1, 32'h0, 32'h1, 1, 35);
      drain("mult_ovf");
      issue(1, 0, 32'h80000000, 32'h80000000, 1, 32'h0, 32'h40000000, 1, 35);
      drain("mult_min_min");
      issue(0, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 35);
      drain("div_-7_2");
      issue(0, 1, 32'd7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 32'h1, 0, 35);
      drain("div_7_-2");
      issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h0, 1, 35);
      drain("div_min_-1");
      issue(0, 1, 32'd100, 32'd0, 1, 32'h0, 32'd100, 1, 2);
      drain("div_by_zero");
      t = cyc;
      issue(1, 0, 32'd5, 32'd6, 0, 32'h0, 32'h0, 0, 0);
      wait_until(t + 10);
      issue(0, 1, 32'd50, 32'd7, 1, 32'd7, 32'd1, 0, 35);
      drain("abort_restart");
      issue(1, 1, 32'd6, 32'd7, 1, 32'd42, 32'h0, 0, 35);
      drain("both_strobes");
      t = cyc;
      issue(1, 0, 32'd9, 32'd9, 0, 32'h0, 32'h0, 0, 0);
      wait_until(t + 20);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("midrst_result", 64'(res), 64'd0);
      chk("midrst_result_hi", 64'(res_hi), 64'd0);
      chk("midrst_exception", 64'(exc), 64'd0);
      chk("midrst_rdy", 64'(rdy), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      chk("midrst_start_cycle", 64'(cyc), 64'(t + 22));
      issue(1, 0, 32'hFFFFFFFB, 32'hFFFFFFFB, 1, 32'd25, 32'h0, 0, 35);
      drain("after_reset");
      t = cyc;
      issue(1, 0, 32'd3, 32'd4, 1, 32'd12, 32'h0, 0, 35);
      wait_until(t + 35);
      issue(0, 1, 32'd9, 32'd4, 1, 32'd2, 32'd1, 0, 35);
      drain("back_to_back");
      repeat (40) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
